jk_seq_ctrl: RTL and testbench
==============================

# jk_seq_ctrl

Command-driven sequencer for a bank of N `ffp_jk` flip-flops. It accepts one command at a time over a valid/ready handshake and drives the bank's J/K inputs for as many clock edges as the command needs: clear, set, load, toggle-mask, or count up/down for a programmed number of steps. It reads the bank's Q outputs back to form counting terms. It sits between the control logic and the JK register bank, so nothing else drives the bank's J/K inputs.

## Interface
- N, default 4: width of the controlled JK bank.
- CW, default 8: width of the step count.

- ck  in  1  clock; the bank and the controller both update on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  operation code (see Operation).
- cmd_data  in  N  load value or toggle mask.
- cmd_steps  in  CW  number of count edges (count ops only).
- abort  in  1  stop the current command.
- q_in  in  N  Q outputs of the bank, fed back.
- j  out  N  J inputs of the bank.
- k  out  N  K inputs of the bank.
- busy  out  1  a command is executing (state RUN).
- done  out  1  one-cycle completion pulse.
- err  out  1  the completed command had a reserved opcode; valid while done=1.
- aborted  out  1  the completed command was cut short by abort; valid while done=1.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1 and j=k=0.
  - When cmd_valid & cmd_ready at an edge: latch op, data and steps, then go to RUN.
  - Remaining-count register rem is loaded at accept:
    - count ops: rem = cmd_steps;
    - all other ops: rem = 1.
- RUN: j/k are combinational from the latched op and q_in, as follows.
  - 0 HOLD: j=0, k=0.
  - 1 CLEAR: j=0, k=all ones.
  - 2 SET: j=all ones, k=0.
  - 3 LOAD: j=data, k=~data.
  - 4 TOGGLE: j=k=data.
  - 5 COUNT UP: j[i]=k[i]=AND(q_in[i-1:0]); bit 0 is 1.
  - 6 COUNT DOWN: j[i]=k[i]=AND(~q_in[i-1:0]); bit 0 is 1.
  - 7 reserved: j=k=0, and err is set at completion.
- rem decrements on every RUN edge. When rem is 1 (or 0) at an edge, go to DONE.
- Count with steps=0: stays one cycle in RUN with j=k=0 forced, so the bank does not change, then goes to DONE.
- abort=1 during RUN:
  - j=k=0 combinationally in that same cycle, so that edge does not change the bank;
  - next state is DONE, with aborted=1.
- abort is ignored in IDLE and DONE.
- DONE: done=1, j=k=0, cmd_ready=0; next state is IDLE. err and aborted are cleared on the next accept.
- Counting wraps modulo 2^N: 1111 + 1 gives 0000, and 0000 − 1 gives 1111.

## Timing
- Reset while rst=1: state IDLE, rem=0, op=HOLD. Outputs: cmd_ready=0, j=k=0, busy=0, done=0, err=0, aborted=0.
- After rst is released: cmd_ready=1 from the first cycle.
- Reset mid-command: the command is dropped immediately; no done pulse.
- Accept edge E0:
  - j/k are valid in the cycle after E0.
  - The bank applies edges E1…ES (S=1 for single-shot ops).
  - busy=1 from E0 to ES.
  - done=1 for the cycle after ES.
  - The next accept is possible at edge ES+2 at the earliest.
- cmd_ready is high only in IDLE (and low during reset). A command held with cmd_valid while the controller is busy waits; it is accepted on the first IDLE edge.
- q_in must be the bank's registered Q. The only combinational path is q_in → j/k, with no feedback loop through the controller.
- j/k change only on ck edges or on abort/rst transitions.

## Test plan
- LOAD 4'b1010 from reset (q=0000) → q=1010 after E1; busy high for 1 cycle, done pulse in the next cycle, err=0.
- COUNT UP with steps=5 after LOAD 1110 → q goes 1111, 0000, 0001, 0010, 0011 on successive edges; done after the 5th edge; wrap is correct.
- COUNT DOWN with steps=3 after LOAD 0001 → q goes 0000, 1111, 1110; then CLEAR → 0000, then SET → 1111, then TOGGLE 0101 → 1010.
- COUNT UP with steps=0 → q unchanged, one RUN cycle, then done. Opcode 7 → q unchanged, done with err=1.
- COUNT UP with steps=10 from 0000, abort asserted in the 4th RUN cycle → q stops at 0011; done with aborted=1; cmd_ready returns the cycle after.
- rst asserted in the middle of a count → j=k=0, busy=0, cmd_ready=0 immediately, no done pulse. After release, a new LOAD is accepted normally.

Source files
------------

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command-driven sequencer for a bank of N JK flip-flops.
// It accepts one command at a time and drives the bank's J/K inputs for
// the edges that command needs. Bank Q is read back to form count terms.
module jk_seq_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_steps,
    input  logic          abort,
    input  logic [N-1:0]  q_in,
    output logic [N-1:0]  j,
    output logic [N-1:0]  k,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          aborted
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    localparam logic [CW-1:0] REM_ONE = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          err_q, err_d;
    logic          aborted_q, aborted_d;

    logic [N-1:0]  up_t, dn_t;
    logic          up_c, dn_c;
    logic          accept;
    logic          is_count;

    // Ready only in IDLE; rst gates it directly so it is low during reset.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign is_count  = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign aborted   = aborted_q;

    // Toggle terms for counting: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        // NOTE: blocking assignments here are intentional; the running carry
        // must be visible to the next loop iteration within the same evaluation.
        up_c = 1'b1;
        dn_c = 1'b1;
        up_t = '0;
        dn_t = '0;
        for (int i = 0; i < N; i++) begin
            up_t[i] = up_c;
            dn_t[i] = dn_c;
            up_c    = up_c & q_in[i];
            dn_c    = dn_c & ~q_in[i];
        end
    end

    // J/K drive: active only in RUN without abort; a zero step count forces no change.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        j = '0;
        k = '0;
        if (state_q == S_RUN && !abort) begin
            case (op_q)
                OP_HOLD:   begin j = '0;      k = '0;      end
                OP_CLEAR:  begin j = '0;      k = '1;      end
                OP_SET:    begin j = '1;      k = '0;      end
                OP_LOAD:   begin j = data_q;  k = ~data_q; end
                OP_TOGGLE: begin j = data_q;  k = data_q;  end
                OP_UP: begin
                    if (rem_q != '0) begin
                        j = up_t;
                        k = up_t;
                    end
                end
                OP_DOWN: begin
                    if (rem_q != '0) begin
                        j = dn_t;
                        k = dn_t;
                    end
                end
                default:   begin j = '0;      k = '0;      end
            endcase
        end
    end

    // Next-state logic: accept in IDLE, count down rem in RUN, one-cycle DONE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        rem_d     = rem_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_RUN;
                    op_d      = cmd_op;
                    data_d    = cmd_data;
                    rem_d     = is_count ? cmd_steps : REM_ONE;
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            S_RUN: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - REM_ONE;
                end
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                    err_d     = (op_q == OP_RSVD);
                end else if (rem_q <= REM_ONE) begin
                    state_d = S_DONE;
                    err_d   = (op_q == OP_RSVD);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and command registers; reset drops any command in flight.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_HOLD;
            data_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb_jk_seq_ctrl: directed test of jk_seq_ctrl driving a 4-bit JK bank
// modelled in the bench. Expected values are hand-computed.
module tb_jk_seq_ctrl;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          ck = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic [CW-1:0] cmd_steps;
    logic          abort;
    logic [N-1:0]  q_bank;
    logic [N-1:0]  j, k;
    logic          busy, done, err, aborted;

    int            n_checks = 0;
    int            n_bad    = 0;
    logic [N-1:0]  hist [0:63];
    logic [N-1:0]  j_first;

    jk_seq_ctrl #(.N(N), .CW(CW)) dut (
        .ck        (ck),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .q_in      (q_bank),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .aborted   (aborted)
    );

    always #5 ck = ~ck;

    // The JK register bank under control.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) q_bank <= '0;
        else     q_bank <= (j & ~q_bank) | (~k & q_bank);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one command from a negedge, run it to completion and check the result.
    // abort_at: RUN cycle (1-based) in which abort is held high, 0 for none.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [N-1:0] data,
                           input logic [CW-1:0] steps, input int abort_at,
                           input logic [N-1:0] exp_q, input int exp_runs,
                           input logic exp_err, input logic exp_ab);
        int  c;
        int  runs;
        bit  seen;
        check({tag, ".ready"}, cmd_ready, 1);
        hist[0]   = q_bank;
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = steps;
        cmd_valid = 1'b1;
        @(posedge ck);
        #1;
        cmd_valid = 1'b0;
        runs = 0;
        seen = 1'b0;
        j_first = '0;
        for (c = 1; c < 64; c++) begin
            abort = (c == abort_at);
            @(negedge ck);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) runs++;
            if (c == 1) j_first = j;
            if (abort) check({tag, ".abort_jk"}, {j, k}, 0);
            @(posedge ck);
            #1;
            hist[c] = q_bank;
        end
        abort = 1'b0;
        check({tag, ".done_seen"}, seen, 1);
        check({tag, ".q"}, q_bank, exp_q);
        check({tag, ".runs"}, runs, exp_runs);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".aborted"}, aborted, exp_ab);
        check({tag, ".done_rdy_jk"}, {cmd_ready, j, k}, 0);
        @(negedge ck);
        check({tag, ".ready_back"}, {cmd_ready, done}, 2'b10);
    endtask

    initial begin
        bit saw_done;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_steps = '0;
        abort     = 1'b0;
        #12;
        check("reset.outs", {cmd_ready, j, k, busy, done, err, aborted}, 0);
        @(negedge ck);
        rst = 1'b0;
        @(negedge ck);

        run_cmd("load1010", 3'd3, 4'b1010, 8'd0, 0, 4'b1010, 1, 1'b0, 1'b0);
        run_cmd("load1110", 3'd3, 4'b1110, 8'd0, 0, 4'b1110, 1, 1'b0, 1'b0);

        run_cmd("up5", 3'd5, 4'b0000, 8'd5, 0, 4'b0011, 5, 1'b0, 1'b0);
        check("up5.j_first", j_first, 4'b0001);
        check("up5.e1", hist[1], 4'b1111);
        check("up5.e2_wrap", hist[2], 4'b0000);
        check("up5.e3", hist[3], 4'b0001);
        check("up5.e4", hist[4], 4'b0010);

        run_cmd("load0001", 3'd3, 4'b0001, 8'd0, 0, 4'b0001, 1, 1'b0, 1'b0);
        run_cmd("dn3", 3'd6, 4'b0000, 8'd3, 0, 4'b1110, 3, 1'b0, 1'b0);
        check("dn3.e1", hist[1], 4'b0000);
        check("dn3.e2_wrap", hist[2], 4'b1111);

        run_cmd("clear", 3'd1, 4'b0000, 8'd0, 0, 4'b0000, 1, 1'b0, 1'b0);
        run_cmd("set", 3'd2, 4'b0000, 8'd0, 0, 4'b1111, 1, 1'b0, 1'b0);
        run_cmd("tog0101", 3'd4, 4'b0101, 8'd0, 0, 4'b1010, 1, 1'b0, 1'b0);
        run_cmd("up0", 3'd5, 4'b0000, 8'd0, 0, 4'b1010, 1, 1'b0, 1'b0);
        check("up0.jk_forced", j_first, 4'b0000);
        run_cmd("rsvd", 3'd7, 4'b1111, 8'd9, 0, 4'b1010, 1, 1'b1, 1'b0);
        run_cmd("hold", 3'd0, 4'b1111, 8'd9, 0, 4'b1010, 1, 1'b0, 1'b0);

        run_cmd("clear2", 3'd1, 4'b0000, 8'd0, 0, 4'b0000, 1, 1'b0, 1'b0);
        run_cmd("up10ab", 3'd5, 4'b0000, 8'd10, 4, 4'b0011, 4, 1'b0, 1'b1);
        run_cmd("after_ab", 3'd3, 4'b0101, 8'd0, 0, 4'b0101, 1, 1'b0, 1'b0);

        // Reset in the middle of a count: outputs drop at once, no done pulse.
        run_cmd("clear3", 3'd1, 4'b0000, 8'd0, 0, 4'b0000, 1, 1'b0, 1'b0);
        cmd_op    = 3'd5;
        cmd_data  = '0;
        cmd_steps = 8'd10;
        cmd_valid = 1'b1;
        @(posedge ck);
        #1;
        cmd_valid = 1'b0;
        @(posedge ck);
        @(posedge ck);
        #2;
        check("midrst.busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst.outs", {cmd_ready, j, k, busy}, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        @(negedge ck);
        if (done) saw_done = 1'b1;
        check("midrst.no_done", saw_done, 0);
        run_cmd("rst_load", 3'd3, 4'b0110, 8'd0, 0, 4'b0110, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
